// File: rtl/mem_access_arbiter_pkg.sv
// Shared opcodes, RW encoding and FSM state encoding for the memory access arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package mem_access_arbiter_pkg;

  localparam logic [3:0] OP_LDR   = 4'b1010;
  localparam logic [3:0] OP_STR   = 4'b1001;
  localparam logic       RW_READ  = 1'b1;
  localparam logic       RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // An opcode is serviceable only if it is a load or a store.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op == OP_LDR) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/mem_access_arbiter_arb_priority_sel.sv
// Fetch vs load/store grant select: DM wins ties until its streak reaches the cap, then IF.
// Latency: combinational.
// Backpressure: the loser simply keeps its request high; nothing is dropped here.
module arb_priority_sel #(
  parameter int MAX_STREAK = 3
) (
  input  logic       if_req,
  input  logic       dm_req,
  input  logic [3:0] streak,
  output logic       grant_if,
  output logic       grant_dm
);

  localparam logic [3:0] STREAK_CAP = 4'(MAX_STREAK);

  // IF wins when alone or when DM has used up its consecutive-grant allowance.
  always_comb begin
    grant_if = if_req && (!dm_req || (streak == STREAK_CAP));
    grant_dm = dm_req && (!if_req || (streak != STREAK_CAP));
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one data RAM between instruction fetch and load/store; serialises accesses.
// Latency: grant -> RAM_LAT access cycles -> one-cycle ack (illegal op: ack next cycle).
// Backpressure: requesters hold req until ack; arbitration only in IDLE, others wait.
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int RAM_LAT    = 2,
  parameter int MAX_STREAK = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic [3:0]  dm_op,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic        dm_err,
  output logic [31:0] rdata,
  output logic        ram_en,
  output logic        ram_rw,
  output logic [15:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        busy
);

  localparam logic [3:0] LAT_LOAD   = 4'(RAM_LAT - 1);
  localparam logic [3:0] STREAK_CAP = 4'(MAX_STREAK);

  state_t      state_q, state_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;
  logic [3:0]  streak_q, streak_d;
  logic        gnt_dm_q, gnt_dm_d;
  logic        if_ack_q, if_ack_d;
  logic        dm_ack_q, dm_ack_d;
  logic        dm_err_q, dm_err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ram_en_q, ram_en_d;
  logic        ram_rw_q, ram_rw_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic        busy_q, busy_d;

  logic grant_if, grant_dm, dm_legal;
  logic unused_dm_addr_hi;

  // Only the low half of the data address reaches the 64K-word RAM.
  assign unused_dm_addr_hi = ^dm_addr[31:16];
  assign dm_legal          = op_is_legal(dm_op);

  arb_priority_sel #(
    .MAX_STREAK (MAX_STREAK)
  ) u_sel (
    .if_req   (if_req),
    .dm_req   (dm_req),
    .streak   (streak_q),
    .grant_if (grant_if),
    .grant_dm (grant_dm)
  );

  // State and datapath registers; reset aborts any access in flight without an ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lat_cnt_q   <= '0;
      streak_q    <= '0;
      gnt_dm_q    <= 1'b0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      dm_err_q    <= 1'b0;
      rdata_q     <= '0;
      ram_en_q    <= 1'b0;
      ram_rw_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      streak_q    <= streak_d;
      gnt_dm_q    <= gnt_dm_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      dm_err_q    <= dm_err_d;
      rdata_q     <= rdata_d;
      ram_en_q    <= ram_en_d;
      ram_rw_q    <= ram_rw_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      busy_q      <= busy_d;
    end
  end

  // Next state: illegal DM ops skip the RAM and go straight to the ack cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_if)      state_d = ST_ACCESS;
        else if (grant_dm) state_d = dm_legal ? ST_ACCESS : ST_DONE;
      end
      ST_ACCESS: if (lat_cnt_q == '0) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs and counters: acks are set on entry to DONE so they are registered pulses.
  always_comb begin
    lat_cnt_d   = lat_cnt_q;
    streak_d    = streak_q;
    gnt_dm_d    = gnt_dm_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    dm_err_d    = 1'b0;
    rdata_d     = rdata_q;
    ram_en_d    = ram_en_q;
    ram_rw_d    = ram_rw_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    busy_d      = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (grant_if) begin
          gnt_dm_d   = 1'b0;
          streak_d   = '0;
          ram_en_d   = 1'b1;
          ram_rw_d   = RW_READ;
          ram_addr_d = if_addr;
          lat_cnt_d  = LAT_LOAD;
        end else if (grant_dm) begin
          gnt_dm_d = 1'b1;
          if (!if_req)                  streak_d = '0;
          else if (streak_q != STREAK_CAP) streak_d = streak_q + 4'd1;
          if (dm_legal) begin
            ram_en_d    = 1'b1;
            ram_rw_d    = (dm_op == OP_LDR) ? RW_READ : RW_WRITE;
            ram_addr_d  = dm_addr[15:0];
            ram_wdata_d = dm_wdata;
            lat_cnt_d   = LAT_LOAD;
          end else begin
            dm_ack_d = 1'b1;
            dm_err_d = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (lat_cnt_q == '0) begin
          ram_en_d = 1'b0;
          if (ram_rw_q == RW_READ) rdata_d = ram_rdata;
          if (gnt_dm_q) dm_ack_d = 1'b1;
          else          if_ack_d = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      default: ;
    endcase
  end

  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign dm_err    = dm_err_q;
  assign rdata     = rdata_q;
  assign ram_en    = ram_en_q;
  assign ram_rw    = ram_rw_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: table of DM transactions plus arbitration/reset sequences.
// Latency: checks ack timing against RAM_LAT=2.
// Backpressure: requests are held until ack, as a real requester would.
module tb_mem_access_arbiter;
  import mem_access_arbiter_pkg::*;

  localparam int RAM_LAT = 2;

  logic        clk, reset;
  logic        if_req, if_ack, dm_req, dm_ack, dm_err;
  logic [15:0] if_addr, ram_addr;
  logic [3:0]  dm_op;
  logic [31:0] dm_addr, dm_wdata, rdata, ram_wdata, ram_rdata;
  logic        ram_en, ram_rw, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [31:0] mem [0:65535];

  mem_access_arbiter #(.RAM_LAT(RAM_LAT), .MAX_STREAK(3)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .dm_req(dm_req), .dm_op(dm_op), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_err(dm_err), .rdata(rdata),
    .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Simple RAM model: preloaded while reset is high, written during write accesses.
  always @(posedge clk) begin
    if (reset) begin
      mem[16'h1234] <= 32'hDEADBEEF;
      mem[16'h0040] <= 32'h11112222;
    end else if (ram_en && !ram_rw) begin
      mem[ram_addr] <= ram_wdata;
    end
  end
  assign ram_rdata = mem[ram_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_en;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  // One DM transaction: drive, watch the RAM side, measure ack latency, check results.
  task automatic dm_txn(input vec_t v, input int idx);
    int t0, en_cnt, lat;
    logic got, ram_ok;
    @(posedge clk); #1;
    dm_req = 1'b1; dm_op = v.op; dm_addr = v.addr; dm_wdata = v.wdata;
    t0 = cyc; en_cnt = 0; lat = -1; got = 1'b0; ram_ok = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (ram_en) begin
        en_cnt++;
        if (ram_addr !== v.addr[15:0] || ram_rw !== (v.op == OP_LDR) ||
            (v.op == OP_STR && ram_wdata !== v.wdata) || busy !== 1'b1)
          ram_ok = 1'b0;
      end
      if (dm_ack) begin
        got = 1'b1;
        lat = cyc - t0;
        chk($sformatf("v%0d_dm_err", idx), {31'd0, dm_err}, {31'd0, v.exp_err});
        chk($sformatf("v%0d_if_ack", idx), {31'd0, if_ack}, 32'd0);
      end
    end
    dm_req = 1'b0;
    chk($sformatf("v%0d_ack_latency", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d_ram_en_cycles", idx), 32'(en_cnt), 32'(v.exp_en));
    chk($sformatf("v%0d_ram_side", idx), {31'd0, ram_ok}, 32'd1);
    chk($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
    @(negedge clk);
    chk($sformatf("v%0d_ack_pulse_idle", idx), {30'd0, dm_ack, busy}, 32'd0);
  endtask

  initial begin
    int t0, dm_c, if_c, n_acks, no_ack;
    logic seen;
    logic [7:0] order;

    reset = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0;
    dm_op = '0; dm_addr = '0; dm_wdata = '0;

    //                op       addr           wdata          err  lat en  rdata
    vecs[0] = '{OP_LDR, 32'h0000_1234, 32'h0,          1'b0, 3, 2, 32'hDEADBEEF};
    vecs[1] = '{OP_STR, 32'h0000_0021, 32'h8,          1'b0, 3, 2, 32'hDEADBEEF};
    vecs[2] = '{OP_LDR, 32'hFFFF_0021, 32'h0,          1'b0, 3, 2, 32'h0000_0008};
    vecs[3] = '{4'b0011, 32'h0000_0050, 32'h0,         1'b1, 1, 0, 32'h0000_0008};
    vecs[4] = '{OP_STR, 32'h0000_1234, 32'hA5A5_5A5A,  1'b0, 3, 2, 32'h0000_0008};
    vecs[5] = '{OP_LDR, 32'h0000_1234, 32'h0,          1'b0, 3, 2, 32'hA5A5_5A5A};
    vecs[6] = '{4'b0000, 32'h0000_1234, 32'h0,         1'b1, 1, 0, 32'hA5A5_5A5A};

    // Reset held two cycles, then idle outputs must all be zero.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ctrl_outs", {26'd0, if_ack, dm_ack, dm_err, ram_en, ram_rw, busy}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ram_addr", {16'd0, ram_addr}, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);

    for (int i = 0; i < 7; i++) dm_txn(vecs[i], i);

    // Simultaneous IF and DM: DM first, IF ack four cycles after DM ack.
    @(posedge clk); #1;
    dm_req = 1'b1; dm_op = OP_LDR; dm_addr = 32'h0000_1234;
    if_req = 1'b1; if_addr = 16'h0040;
    t0 = cyc; dm_c = -100; if_c = -1; seen = 1'b0;
    for (int k = 0; k < 30 && if_c < 0; k++) begin
      @(negedge clk);
      if (dm_ack && dm_c < 0) begin
        dm_c = cyc;
        dm_req = 1'b0;
        chk("both_dm_rdata", rdata, 32'hA5A5_5A5A);
      end
      if (ram_en && dm_c >= 0 && !seen) begin
        seen = 1'b1;
        chk("both_if_ram_addr", {16'd0, ram_addr}, 32'h0000_0040);
        chk("both_if_ram_rw", {31'd0, ram_rw}, 32'd1);
      end
      if (if_ack) begin
        if_c = cyc;
        if_req = 1'b0;
      end
    end
    chk("both_dm_latency", 32'(dm_c - t0), 32'd3);
    chk("both_if_after_dm", 32'(if_c - dm_c), 32'd4);
    chk("both_if_rdata", rdata, 32'h1111_2222);

    // Both held continuously: DM gets three in a row, then IF, and the streak restarts.
    @(posedge clk); #1;
    dm_req = 1'b1; dm_op = OP_LDR; dm_addr = 32'h0000_1234;
    if_req = 1'b1; if_addr = 16'h0040;
    order = '0; n_acks = 0;
    for (int k = 0; k < 100 && n_acks < 8; k++) begin
      @(negedge clk);
      if (dm_ack && if_ack) chk("streak_double_ack", 32'd1, 32'd0);
      if (dm_ack) begin
        order = {order[6:0], 1'b1}; n_acks++;
      end else if (if_ack) begin
        order = {order[6:0], 1'b0}; n_acks++;
      end
    end
    dm_req = 1'b0; if_req = 1'b0;
    chk("streak_ack_count", 32'(n_acks), 32'd8);
    chk("streak_grant_order", {24'd0, order}, 32'h0000_00EE);

    // Reset asserted mid-access: back to IDLE at once and no ack afterwards.
    @(negedge clk);
    @(posedge clk); #1;
    dm_req = 1'b1; dm_op = OP_LDR; dm_addr = 32'h0000_0040;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_in_access", {30'd0, ram_en, busy}, 32'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; dm_req = 1'b0;
    chk("midrst_idle", {29'd0, ram_en, busy, dm_ack}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    no_ack = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (dm_ack || if_ack || ram_en) no_ack++;
    end
    chk("midrst_no_ack", 32'(no_ack), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
